// File: rtl/stereo_axis_pkg.sv
// rtl/stereo_axis_pkg.sv - shared types for the stereo AXIS transmit bridge
package stereo_axis_pkg;

    localparam int frame_channel_width = 24;

    typedef enum logic [1:0] {
        IDLE,
        SEND_L,
        SEND_R
    } state_e;

    typedef struct packed {
        logic [frame_channel_width-1:0] left;
        logic [frame_channel_width-1:0] right;
    } frame_t;

endpackage

// File: rtl/frame_fifo2.sv
// rtl/frame_fifo2.sv - two-entry register FIFO with registered count/full/empty
module frame_fifo2 #(
    parameter int width_p = 48
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic               push_i,
    input  logic               pop_i,
    input  logic [width_p-1:0] data_i,
    output logic [width_p-1:0] head_o,
    output logic [width_p-1:0] next_o,
    output logic [1:0]         count_o,
    output logic               full_o,
    output logic               empty_o
);

    logic       do_push;
    logic       do_pop;
    logic [1:0] count_next;

    // A push into a full FIFO is only honoured when a pop frees the slot.
    assign do_push = push_i & (~full_o | pop_i);
    assign do_pop  = pop_i & ~empty_o;

    always_comb begin
        count_next = count_o + {1'b0, do_push} - {1'b0, do_pop};
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            head_o  <= '0;
            next_o  <= '0;
            count_o <= 2'd0;
            full_o  <= 1'b0;
            empty_o <= 1'b1;
        end else begin
            case ({do_push, do_pop})
                2'b10: begin
                    if (count_o == 2'd0) head_o <= data_i;
                    else                 next_o <= data_i;
                end
                2'b01: head_o <= next_o;
                2'b11: begin
                    if (count_o == 2'd1) begin
                        head_o <= data_i;
                    end else begin
                        head_o <= next_o;
                        next_o <= data_i;
                    end
                end
                default: ;
            endcase
            count_o <= count_next;
            full_o  <= (count_next == 2'd2);
            empty_o <= (count_next == 2'd0);
        end
    end

endmodule

// File: rtl/stereo_axis_tx.sv
// rtl/stereo_axis_tx.sv - buffers stereo frames and emits them as left/right AXIS beats
module stereo_axis_tx
    import stereo_axis_pkg::*;
#(
    parameter int channel_width_p = 24,
    parameter int axis_width_p    = 32,
    parameter int sign_extend_p   = 0,
    parameter int count_width_p   = 16
) (
    input  logic                       clk_i,
    input  logic                       reset_n_i,
    input  logic [channel_width_p-1:0] left_i,
    input  logic [channel_width_p-1:0] right_i,
    input  logic                       valid_i,
    output logic                       ready_o,
    output logic [axis_width_p-1:0]    tx_tdata_o,
    output logic                       tx_tvalid_o,
    input  logic                       tx_tready_i,
    output logic                       tx_tlast_o,
    output logic [count_width_p-1:0]   frames_sent_o,
    output logic                       busy_o
);

    localparam int fw = 2 * channel_width_p;

    state_e                     state_q;
    logic                       started_q;
    logic                       push;
    logic                       pop;
    logic [fw-1:0]              head;
    logic [fw-1:0]              nxt;
    logic [1:0]                 count;
    logic [1:0]                 count_next;
    logic                       full;
    logic                       empty;
    logic [channel_width_p-1:0] idle_left;
    logic [channel_width_p-1:0] after_pop_left;
    logic                       unused_next_right;

    function automatic logic [axis_width_p-1:0] ext(input logic [channel_width_p-1:0] s);
        logic [axis_width_p-1:0] r;
        r = (sign_extend_p != 0 && s[channel_width_p-1]) ? '1 : '0;
        r[channel_width_p-1:0] = s;
        return r;
    endfunction

    // started_q keeps ready_o low while reset is held and until the first edge.
    assign ready_o     = started_q & ~full;
    assign push        = valid_i & ready_o;
    assign pop         = (state_q == SEND_R) & tx_tready_i;
    assign count_next  = count + {1'b0, push} - {1'b0, pop};
    assign tx_tvalid_o = (state_q != IDLE);
    assign busy_o      = ~empty | (state_q != IDLE);

    // Left sample of whichever frame becomes head after this edge.
    assign idle_left         = empty ? left_i : head[fw-1:channel_width_p];
    assign after_pop_left    = (count == 2'd2) ? nxt[fw-1:channel_width_p] : left_i;
    assign unused_next_right = ^nxt[channel_width_p-1:0];

    frame_fifo2 #(
        .width_p (fw)
    ) u_fifo (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .push_i    (push),
        .pop_i     (pop),
        .data_i    ({left_i, right_i}),
        .head_o    (head),
        .next_o    (nxt),
        .count_o   (count),
        .full_o    (full),
        .empty_o   (empty)
    );

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q       <= IDLE;
            started_q     <= 1'b0;
            tx_tdata_o    <= '0;
            tx_tlast_o    <= 1'b0;
            frames_sent_o <= '0;
        end else begin
            started_q <= 1'b1;
            if (pop && frames_sent_o != {count_width_p{1'b1}}) begin
                frames_sent_o <= frames_sent_o + 1'b1;
            end
            case (state_q)
                IDLE: begin
                    if (count_next != 2'd0) begin
                        state_q    <= SEND_L;
                        tx_tdata_o <= ext(idle_left);
                        tx_tlast_o <= 1'b0;
                    end
                end
                SEND_L: begin
                    if (tx_tready_i) begin
                        state_q    <= SEND_R;
                        tx_tdata_o <= ext(head[channel_width_p-1:0]);
                        tx_tlast_o <= 1'b1;
                    end
                end
                SEND_R: begin
                    if (tx_tready_i) begin
                        if (count_next != 2'd0) begin
                            state_q    <= SEND_L;
                            tx_tdata_o <= ext(after_pop_left);
                            tx_tlast_o <= 1'b0;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
